// File: rtl/nco_iq_demod_pkg.sv
// Shared types for the NCO I/Q lock-in demodulator: FSM state encoding and accumulator width.
// No logic, no latency, no flow control.
// Imported by nco_iq_demod and nco_iq_mac.
package nco_iq_demod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int acw_width(input int mpr, input int adw, input int nacc_log2);
        return mpr + adw + nacc_log2;
    endfunction

endpackage

// File: rtl/nco_iq_mac.sv
// One-channel registered multiply (stage 1) and accumulate (stage 2) with sticky overflow.
// Latency: product one enabled cycle after vld_i, accumulator one enabled cycle later.
// No backpressure; NCO_IQ_DEMOD_SAT_EN selects saturating instead of wrapping accumulation.
module nco_iq_mac
    import nco_iq_demod_pkg::*;
#(
    parameter int ADW = 14,
    parameter int MPR = 14,
    parameter int ACW = 38
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  clr_i,
    input  logic                  vld_i,
    input  logic signed [ADW-1:0] a_i,
    input  logic signed [MPR-1:0] b_i,
    output logic                  p_vld_o,
    output logic signed [ACW-1:0] acc_o,
    output logic                  ovf_o
);
    localparam int PW = MPR + ADW;

`ifdef NCO_IQ_DEMOD_SAT_EN
    localparam logic signed [ACW-1:0] SMAX = {1'b0, {(ACW-1){1'b1}}};
    localparam logic signed [ACW-1:0] SMIN = {1'b1, {(ACW-1){1'b0}}};
`endif

    logic signed [PW-1:0]  p_d, p_q;
    logic                  p_vld_d, p_vld_q;
    logic signed [ACW-1:0] acc_d, acc_q;
    logic                  ovf_d, ovf_q;
    logic signed [ACW-1:0] p_ext, sum;
    logic                  add_ovf;

    always_comb begin
        p_d     = p_q;
        p_vld_d = vld_i;
        if (vld_i) begin
            p_d = PW'(a_i) * PW'(b_i);
        end

        p_ext   = ACW'(p_q);
        sum     = acc_q + p_ext;
        // Signed overflow: operands agree in sign but the sum does not.
        add_ovf = (acc_q[ACW-1] == p_ext[ACW-1]) && (sum[ACW-1] != acc_q[ACW-1]);

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (p_vld_q) begin
            ovf_d = ovf_q | add_ovf;
`ifdef NCO_IQ_DEMOD_SAT_EN
            if (add_ovf) begin
                acc_d = p_ext[ACW-1] ? SMIN : SMAX;
            end else begin
                acc_d = sum;
            end
`else
            acc_d = sum;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clken) begin
            p_q     <= p_d;
            p_vld_q <= p_vld_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign p_vld_o = p_vld_q;
    assign acc_o   = acc_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/nco_iq_demod.sv
// Lock-in I/Q detector: mixes ADC samples with NCO cos/sin and integrates 2^NACC_LOG2 products.
// Latency: last accepted sample at enabled cycle t gives result_valid_o at t+3.
// No backpressure; samples without both valids are dropped. NCO_IQ_DEMOD_SAT_EN: saturating sums.
module nco_iq_demod
    import nco_iq_demod_pkg::*;
#(
    parameter int MPR       = 14,
    parameter int ADW       = 14,
    parameter int NACC_LOG2 = 10,
    parameter int ACW       = acw_width(MPR, ADW, NACC_LOG2)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  start_i,
    input  logic signed [ADW-1:0] adc_data_i,
    input  logic                  adc_valid_i,
    input  logic signed [MPR-1:0] fsin_i,
    input  logic signed [MPR-1:0] fcos_i,
    input  logic                  nco_valid_i,
    output logic signed [ACW-1:0] i_o,
    output logic signed [ACW-1:0] q_o,
    output logic                  result_valid_o,
    output logic                  busy_o,
    output logic                  overflow_o
);
    state_t                 state_d, state_q;
    logic [NACC_LOG2-1:0]   cnt_d, cnt_q;
    logic                   busy_d, busy_q;
    logic                   rv_d, rv_q;
    logic signed [ACW-1:0]  i_d, i_q, q_d, q_q;

    logic                   accept, clr;
    logic                   i_pvld, q_pvld, i_ovf, q_ovf;
    logic signed [ACW-1:0]  i_acc, q_acc;

    assign accept = (state_q == ST_ACC) && adc_valid_i && nco_valid_i;
    assign clr    = (state_q == ST_IDLE) && start_i;

    nco_iq_mac #(.ADW(ADW), .MPR(MPR), .ACW(ACW)) u_mac_i (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .clr_i   (clr),
        .vld_i   (accept),
        .a_i     (adc_data_i),
        .b_i     (fcos_i),
        .p_vld_o (i_pvld),
        .acc_o   (i_acc),
        .ovf_o   (i_ovf)
    );

    nco_iq_mac #(.ADW(ADW), .MPR(MPR), .ACW(ACW)) u_mac_q (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .clr_i   (clr),
        .vld_i   (accept),
        .a_i     (adc_data_i),
        .b_i     (fsin_i),
        .p_vld_o (q_pvld),
        .acc_o   (q_acc),
        .ovf_o   (q_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rv_d    = 1'b0;
        i_d     = i_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ACC;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Stage 1 empty means the final product has already landed in the accumulator.
                if (!(i_pvld | q_pvld)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    rv_d    = 1'b1;
                    i_d     = i_acc;
                    q_d     = q_acc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
        end else if (clken) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

    assign i_o            = i_q;
    assign q_o            = q_q;
    assign result_valid_o = rv_q;
    assign busy_o         = busy_q;
    assign overflow_o     = i_ovf | q_ovf;

endmodule
